// File: rtl/pc_if.sv
// Fetch-stage program counter bus: the command/operand inputs and the registered address/strobe outputs.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PCSet;
  logic [2:0]       PCDrive;
  logic [WIDTH-1:0] PCAddr;
  logic             GetInstruction;

  modport master (
    output PCSet,
    output PCDrive,
    input  PCAddr,
    input  GetInstruction
  );

  modport slave (
    input  PCSet,
    input  PCDrive,
    output PCAddr,
    output GetInstruction
  );
endinterface

// File: rtl/pc.sv
// Program counter: hold/inc/load/fwd/back commands, optional word alignment under PC_ALIGN_EN.
// Latency 1 cycle (PCAddr and GetInstruction update together); no backpressure, a command is taken every edge.
module pc #(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned       INC_STEP   = 4
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  localparam logic [2:0] CMD_HOLD = 3'b000;
  localparam logic [2:0] CMD_INC  = 3'b001;
  localparam logic [2:0] CMD_LOAD = 3'b010;
  localparam logic [2:0] CMD_FWD  = 3'b011;
  localparam logic [2:0] CMD_BACK = 3'b100;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

`ifdef PC_ALIGN_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
`else
  localparam logic [WIDTH-1:0] ALIGN_MASK = '1;
`endif

  localparam logic [WIDTH-1:0] RESET_VAL = RESET_ADDR & ALIGN_MASK;

  logic [WIDTH-1:0] pc_addr_q, pc_addr_d;
  logic [WIDTH-1:0] pc_raw;
  logic             get_instr_q, get_instr_d;

  always_comb begin
    pc_raw      = pc_addr_q;
    get_instr_d = 1'b0;
    case (bus.PCDrive)
      CMD_HOLD: begin
        pc_raw      = pc_addr_q;
        get_instr_d = 1'b0;
      end
      CMD_INC: begin
        pc_raw      = pc_addr_q + STEP;
        get_instr_d = 1'b1;
      end
      CMD_LOAD: begin
        pc_raw      = bus.PCSet;
        get_instr_d = 1'b1;
      end
      CMD_FWD: begin
        pc_raw      = pc_addr_q + bus.PCSet;
        get_instr_d = 1'b1;
      end
      CMD_BACK: begin
        pc_raw      = pc_addr_q - bus.PCSet;
        get_instr_d = 1'b1;
      end
      // Reserved and unknown codes fall back to HOLD.
      default: begin
        pc_raw      = pc_addr_q;
        get_instr_d = 1'b0;
      end
    endcase
    pc_addr_d = pc_raw & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_addr_q   <= RESET_VAL;
      get_instr_q <= 1'b0;
    end else begin
      pc_addr_q   <= pc_addr_d;
      get_instr_q <= get_instr_d;
    end
  end

  assign bus.PCAddr         = pc_addr_q;
  assign bus.GetInstruction = get_instr_q;

endmodule

// File: tb/tb_pc.sv
// Directed-vector bench for pc; expected outputs are queued at issue and checked by an independent monitor.
module tb_pc;

  localparam int NVEC = 20;

  typedef struct {
    logic        rst;
    logic [2:0]  drv;
    logic [31:0] set;
    logic [31:0] addr;
    logic        gi;
  } vec_t;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] addr;
    logic        gi;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[NVEC];

  pc_if #(.WIDTH(32)) bus ();

  pc #(.WIDTH(32), .RESET_ADDR(32'h0), .INC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at each falling edge, check every expectation due in this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (bus.PCAddr !== e.addr) begin
        n_fail++;
        $display("FAIL pcaddr vec%0d: got %h, expected %h", e.idx, bus.PCAddr, e.addr);
      end
      n_checks++;
      if (bus.GetInstruction !== e.gi) begin
        n_fail++;
        $display("FAIL getinstr vec%0d: got %b, expected %b", e.idx, bus.GetInstruction, e.gi);
      end
    end
  end

  initial begin
    int wait_cyc;
    exp_t e;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst         = 1'b1;
    bus.PCDrive = 3'b011;
    bus.PCSet   = 32'd10;

    //        rst   drv     set            expected addr  gi
    vecs = '{
      '{1'b1, 3'b011, 32'd10,        32'd0,         1'b0},
      '{1'b1, 3'b011, 32'd10,        32'd0,         1'b0},
      '{1'b0, 3'b000, 32'd10,        32'd0,         1'b0},
      '{1'b0, 3'b011, 32'd10,        32'd10,        1'b1},
      '{1'b0, 3'b000, 32'd25,        32'd10,        1'b0},
      '{1'b0, 3'b001, 32'd25,        32'd14,        1'b1},
      '{1'b0, 3'b010, 32'd30,        32'd30,        1'b1},
      '{1'b0, 3'b100, 32'd33,        32'hFFFF_FFFD, 1'b1},
      '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1},
      '{1'b0, 3'b001, 32'd0,         32'h0000_0002, 1'b1},
      '{1'b0, 3'b111, 32'd55,        32'h0000_0002, 1'b0},
      '{1'b0, 3'b101, 32'd55,        32'h0000_0002, 1'b0},
      '{1'b0, 3'b110, 32'd55,        32'h0000_0002, 1'b0},
      '{1'b1, 3'b010, 32'h100,       32'd0,         1'b0},
      '{1'b0, 3'b010, 32'h100,       32'h100,       1'b1},
      '{1'b0, 3'b011, 32'hF00,       32'h1000,      1'b1},
      '{1'b0, 3'b100, 32'h1001,      32'hFFFF_FFFF, 1'b1},
      '{1'b0, 3'b001, 32'd0,         32'h0000_0003, 1'b1},
      '{1'b0, 3'b000, 32'd0,         32'h0000_0003, 1'b0},
      '{1'b0, 3'b000, 32'hDEAD,      32'h0000_0003, 1'b0}
    };

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      rst         = vecs[i].rst;
      bus.PCDrive = vecs[i].drv;
      bus.PCSet   = vecs[i].set;
      e.due  = cyc + 1;
      e.idx  = i;
      e.addr = vecs[i].addr;
      e.gi   = vecs[i].gi;
      sb.push_back(e);
    end

    @(posedge clk);
    #1;
    bus.PCDrive = 3'b000;

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
